// File: rtl/dmem_rr_responder_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
//   Shared definitions for the data-memory responder and its arbiter:
//   SC result codes, the hart-index width helper and the packed request
//   record the responder builds for the granted hart.
// ---------------------------------------------------------------------------
package dmem_pkg;

  localparam int          DATA_W     = 32;
  localparam logic [31:0] SC_SUCCESS = 32'd0;
  localparam logic [31:0] SC_FAIL    = 32'd1;

  // Hart-index width; a single hart still needs a 1-bit index.
  function automatic int hart_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic        re;
    logic        we;
    logic        lr;
    logic        sc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } dmem_req_t;

endpackage

// File: rtl/dmem_rr_responder_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Round-robin single-grant arbiter. The search starts at ptr and walks
//   ptr, ptr+1, ... modulo N. After a grant to hart g the pointer moves to
//   g+1; with no request it holds.
//
// Ports
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset (ptr -> 0)
//   req        per-requester request, level
//   grant      one-hot grant, combinational
//   grant_idx  binary index of the granted requester (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter
  import dmem_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = hart_idx_w(N)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr;
  logic          found;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[wrap_idx(ptr, i)]) begin
        found                   = 1'b1;
        grant[wrap_idx(ptr, i)] = 1'b1;
        grant_idx               = wrap_idx(ptr, i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_rr_responder.sv
// ---------------------------------------------------------------------------
// dmem_rr_responder
//   Shared data-memory responder. NCORES harts issue load / store / LR.W /
//   SC.W requests; one is granted per cycle by a round-robin arbiter and
//   retired against a single-port word memory, the rest see stall.
//   Reads return one cycle after the grant and hold until that hart's next
//   read or SC. Optional LR/SC reservation tracking is enabled by defining
//   DMEM_RSV_EN; without it LR is a plain read and SC always writes and
//   returns SC_SUCCESS.
//
// Ports
//   clk_i           system clock
//   rst_ni          asynchronous active-low reset
//   re_packed_i     [NCORES]            read request per hart
//   we_packed_i     [NCORES]            write request per hart
//   addr_packed_i   [DMEM_ADDRW*NCORES] word address, hart k at slice k
//   wdata_packed_i  [32*NCORES]         write data
//   wstrb_packed_i  [4*NCORES]          byte strobes
//   is_lr_packed_i  [NCORES]            read is LR.W
//   is_sc_packed_i  [NCORES]            write is SC.W
//   rdata_packed_o  [32*NCORES]         registered read data / SC result
//   stall_packed_o  [NCORES]            combinational stall (req & ~grant)
// ---------------------------------------------------------------------------
module dmem_rr_responder
  import dmem_pkg::*;
#(
  parameter int NCORES     = 2,
  parameter int DMEM_ADDRW = 12
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NCORES-1:0]            re_packed_i,
  input  logic [NCORES-1:0]            we_packed_i,
  input  logic [DMEM_ADDRW*NCORES-1:0] addr_packed_i,
  input  logic [32*NCORES-1:0]         wdata_packed_i,
  input  logic [4*NCORES-1:0]          wstrb_packed_i,
  input  logic [NCORES-1:0]            is_lr_packed_i,
  input  logic [NCORES-1:0]            is_sc_packed_i,
  output logic [32*NCORES-1:0]         rdata_packed_o,
  output logic [NCORES-1:0]            stall_packed_o
);

  localparam int IW    = hart_idx_w(NCORES);
  localparam int DEPTH = 2 ** DMEM_ADDRW;

  dmem_req_t             reqs [NCORES];
  dmem_req_t             sel;
  logic [NCORES-1:0]     req;
  logic [NCORES-1:0]     grant;
  logic [IW-1:0]         gidx;
  logic                  gvld;
  logic [DMEM_ADDRW-1:0] addr;
  logic                  sc_ok;
  logic                  do_write;
  logic [DATA_W-1:0]     sc_code;
  logic                  unused_bits;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DATA_W-1:0]     rd_word_p1;
  logic [NCORES-1:0]     vld_p1;
  logic [DATA_W-1:0]     hold [NCORES];
  logic [DATA_W-1:0]     rdata [NCORES];

  for (genvar k = 0; k < NCORES; k++) begin : g_req
    assign reqs[k] = '{
      re:    re_packed_i[k],
      we:    we_packed_i[k],
      lr:    is_lr_packed_i[k],
      sc:    is_sc_packed_i[k],
      addr:  32'(addr_packed_i[k*DMEM_ADDRW +: DMEM_ADDRW]),
      wdata: wdata_packed_i[k*32 +: 32],
      wstrb: wstrb_packed_i[k*4 +: 4]
    };
    assign rdata[k]                 = vld_p1[k] ? rd_word_p1 : hold[k];
    assign rdata_packed_o[k*32 +: 32] = rdata[k];
  end

  assign req = re_packed_i | we_packed_i;

  rr_arbiter #(
    .N  (NCORES),
    .IW (IW)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req       (req),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign stall_packed_o = req & ~grant;
  assign gvld           = |grant;
  assign sel            = reqs[gidx];
  assign addr           = sel.addr[DMEM_ADDRW-1:0];
  // Upper address bits are zero by construction; lr is only consumed when
  // reservations are built in.
  assign unused_bits    = ^{sel.addr[31:DMEM_ADDRW], sel.lr};

`ifdef DMEM_RSV_EN
  logic [NCORES-1:0]     rsv_v;
  logic [DMEM_ADDRW-1:0] rsv_a [NCORES];

  assign sc_ok = rsv_v[gidx] && (rsv_a[gidx] == addr);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsv_v <= '0;
    end else if (gvld) begin
      // Any committed write kills every reservation on that word; the
      // granted hart's own LR/SC update below takes precedence.
      if (do_write) begin
        for (int j = 0; j < NCORES; j++) begin
          if (rsv_a[j] == addr) rsv_v[j] <= 1'b0;
        end
      end
      if (sel.lr) rsv_v[gidx] <= 1'b1;
      if (sel.sc) rsv_v[gidx] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (gvld && sel.lr) rsv_a[gidx] <= addr;
  end
`else
  assign sc_ok = 1'b1;
`endif

  assign sc_code  = sc_ok ? SC_SUCCESS : SC_FAIL;
  // rst_ni gates the write so grants seen while in reset leave memory untouched.
  assign do_write = gvld & sel.we & (~sel.sc | sc_ok) & rst_ni;

  // ---- stage p0 -> p1: memory access and result capture ----
  always_ff @(posedge clk_i) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (sel.wstrb[b]) mem[addr][8*b +: 8] <= sel.wdata[8*b +: 8];
      end
    end
    if (gvld) rd_word_p1 <= sel.sc ? sc_code : mem[addr];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1 <= '0;
      for (int k = 0; k < NCORES; k++) hold[k] <= '0;
    end else begin
      vld_p1 <= grant & (re_packed_i | is_sc_packed_i);
      // ---- stage p1 -> hold: latch the presented word per hart ----
      for (int k = 0; k < NCORES; k++) begin
        if (vld_p1[k]) hold[k] <= rd_word_p1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_rr_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_rr_responder
//   Directed bench for dmem_rr_responder (NCORES=2, DMEM_ADDRW=12).
//   A table of per-cycle vectors covers stores, strobes, contention and
//   LR/SC; hand-written sequences cover reset in the middle of contention.
//   Expected LR/SC outcomes follow DMEM_RSV_EN.
// ---------------------------------------------------------------------------
module tb_dmem_rr_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  re, we, is_lr, is_sc;
  logic [23:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic [63:0] rdata;
  logic [1:0]  stall;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef DMEM_RSV_EN
  localparam logic [31:0] EXP_SC_CONF = 32'd1;
  localparam logic [31:0] EXP_MEM_CONF = 32'd7;
  localparam logic [31:0] EXP_MEM_RST = 32'd7;
  localparam logic [31:0] EXP_SC_RST  = 32'd1;
`else
  localparam logic [31:0] EXP_SC_CONF = 32'd0;
  localparam logic [31:0] EXP_MEM_CONF = 32'd9;
  localparam logic [31:0] EXP_MEM_RST = 32'h77;
  localparam logic [31:0] EXP_SC_RST  = 32'd0;
`endif

  dmem_rr_responder #(
    .NCORES     (2),
    .DMEM_ADDRW (12)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .re_packed_i    (re),
    .we_packed_i    (we),
    .addr_packed_i  (addr),
    .wdata_packed_i (wdata),
    .wstrb_packed_i (wstrb),
    .is_lr_packed_i (is_lr),
    .is_sc_packed_i (is_sc),
    .rdata_packed_o (rdata),
    .stall_packed_o (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  re, we, lr, sc;
    logic [11:0] a0, a1;
    logic [31:0] d0, d1;
    logic [3:0]  s0, s1;
    logic [1:0]  st;
    logic [1:0]  chk;
    logic [31:0] r0, r1;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic [1:0] v_re, v_we, v_lr, v_sc,
    input logic [11:0] v_a0, v_a1,
    input logic [31:0] v_d0, v_d1,
    input logic [3:0] v_s0, v_s1,
    input logic [1:0] v_st, v_chk,
    input logic [31:0] v_r0, v_r1);
    vec_t v;
    v.re = v_re; v.we = v_we; v.lr = v_lr; v.sc = v_sc;
    v.a0 = v_a0; v.a1 = v_a1; v.d0 = v_d0; v.d1 = v_d1;
    v.s0 = v_s0; v.s1 = v_s1; v.st = v_st; v.chk = v_chk;
    v.r0 = v_r0; v.r1 = v_r1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    re    = v.re;
    we    = v.we;
    is_lr = v.lr;
    is_sc = v.sc;
    addr  = {v.a1, v.a0};
    wdata = {v.d1, v.d0};
    wstrb = {v.s1, v.s0};
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t idle;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle = mk(2'b00, 2'b00, 2'b00, 2'b00, 12'h0, 12'h0, 32'h0, 32'h0, 4'h0, 4'h0,
              2'b00, 2'b00, 32'h0, 32'h0);

    //           re     we     lr     sc     a0      a1      d0            d1            s0    s1    st     chk    r0            r1
    tbl[0]  = mk(2'b00, 2'b01, 2'b00, 2'b00, 12'h010, 12'h000, 32'hDEADBEEF, 32'h0,        4'hF, 4'h0, 2'b00, 2'b11, 32'h0,        32'h0);
    tbl[1]  = mk(2'b01, 2'b00, 2'b00, 2'b00, 12'h010, 12'h000, 32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b00, 32'h0,        32'h0);
    tbl[2]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b01, 32'hDEADBEEF, 32'h0);
    tbl[3]  = mk(2'b00, 2'b01, 2'b00, 2'b00, 12'h020, 12'h000, 32'h11223344, 32'h0,        4'hF, 4'h0, 2'b00, 2'b11, 32'hDEADBEEF, 32'h0);
    tbl[4]  = mk(2'b00, 2'b10, 2'b00, 2'b00, 12'h000, 12'h020, 32'h0,        32'hAABBCCDD, 4'h0, 4'h5, 2'b00, 2'b00, 32'h0,        32'h0);
    tbl[5]  = mk(2'b10, 2'b00, 2'b00, 2'b00, 12'h000, 12'h020, 32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b00, 32'h0,        32'h0);
    tbl[6]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b11, 32'hDEADBEEF, 32'h11BB33DD);
    tbl[7]  = mk(2'b11, 2'b00, 2'b00, 2'b00, 12'h020, 12'h010, 32'h0,        32'h0,        4'h0, 4'h0, 2'b10, 2'b00, 32'h0,        32'h0);
    tbl[8]  = mk(2'b11, 2'b00, 2'b00, 2'b00, 12'h020, 12'h010, 32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 2'b11, 32'h11BB33DD, 32'h11BB33DD);
    tbl[9]  = mk(2'b11, 2'b00, 2'b00, 2'b00, 12'h020, 12'h010, 32'h0,        32'h0,        4'h0, 4'h0, 2'b10, 2'b11, 32'h11BB33DD, 32'hDEADBEEF);
    tbl[10] = mk(2'b00, 2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b11, 32'h11BB33DD, 32'hDEADBEEF);
    tbl[11] = mk(2'b00, 2'b10, 2'b00, 2'b00, 12'h000, 12'h040, 32'h0,        32'h33,       4'h0, 4'hF, 2'b00, 2'b00, 32'h0,        32'h0);
    tbl[12] = mk(2'b01, 2'b00, 2'b01, 2'b00, 12'h040, 12'h000, 32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b00, 32'h0,        32'h0);
    tbl[13] = mk(2'b00, 2'b01, 2'b00, 2'b01, 12'h040, 12'h000, 32'h5,        32'h0,        4'hF, 4'h0, 2'b00, 2'b01, 32'h33,       32'h0);
    tbl[14] = mk(2'b10, 2'b00, 2'b00, 2'b00, 12'h000, 12'h040, 32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b01, 32'h0,        32'h0);
    tbl[15] = mk(2'b00, 2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b11, 32'h0,        32'h5);
    tbl[16] = mk(2'b01, 2'b00, 2'b01, 2'b00, 12'h040, 12'h000, 32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b00, 32'h0,        32'h0);
    tbl[17] = mk(2'b00, 2'b10, 2'b00, 2'b00, 12'h000, 12'h040, 32'h0,        32'h7,        4'h0, 4'hF, 2'b00, 2'b01, 32'h5,        32'h0);
    tbl[18] = mk(2'b00, 2'b01, 2'b00, 2'b01, 12'h040, 12'h000, 32'h9,        32'h0,        4'hF, 4'h0, 2'b00, 2'b00, 32'h0,        32'h0);
    tbl[19] = mk(2'b10, 2'b00, 2'b00, 2'b00, 12'h000, 12'h040, 32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b01, EXP_SC_CONF,  32'h0);
    tbl[20] = mk(2'b00, 2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b11, EXP_SC_CONF,  EXP_MEM_CONF);
    tbl[21] = mk(2'b00, 2'b11, 2'b00, 2'b00, 12'h100, 12'h100, 32'hA1A1A1A1, 32'hB2B2B2B2, 4'hF, 4'hF, 2'b10, 2'b00, 32'h0,        32'h0);
    tbl[22] = mk(2'b00, 2'b11, 2'b00, 2'b00, 12'h100, 12'h100, 32'hA1A1A1A1, 32'hB2B2B2B2, 4'hF, 4'hF, 2'b01, 2'b00, 32'h0,        32'h0);
    tbl[23] = mk(2'b01, 2'b00, 2'b00, 2'b00, 12'h100, 12'h000, 32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b00, 32'h0,        32'h0);
    tbl[24] = mk(2'b00, 2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b01, 32'hB2B2B2B2, 32'h0);

    // ---- reset state ----
    rst_n = 1'b0;
    drive(idle);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset stall", 32'(stall), 32'h0);
    check("reset rdata0", rdata[31:0], 32'h0);
    check("reset rdata1", rdata[63:32], 32'h0);
    rst_n = 1'b1;

    // ---- table-driven vectors ----
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      #4;
      check($sformatf("row%0d stall", i), 32'(stall), 32'(tbl[i].st));
      if (tbl[i].chk[0]) check($sformatf("row%0d rdata0", i), rdata[31:0], tbl[i].r0);
      if (tbl[i].chk[1]) check($sformatf("row%0d rdata1", i), rdata[63:32], tbl[i].r1);
      step();
    end

    // ---- reset during contention with ptr=1 ----
    // hart 0 takes a reservation on 0x040 first, leaving ptr at 1
    drive(mk(2'b01, 2'b00, 2'b01, 2'b00, 12'h040, 12'h000, 32'h0, 32'h0, 4'h0, 4'h0,
             2'b00, 2'b00, 32'h0, 32'h0));
    #4;
    check("pre-rst lr stall", 32'(stall), 32'h0);
    step();
    drive(mk(2'b11, 2'b00, 2'b00, 2'b00, 12'h010, 12'h020, 32'h0, 32'h0, 4'h0, 4'h0,
             2'b00, 2'b00, 32'h0, 32'h0));
    #4;
    check("pre-rst contend stall", 32'(stall), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("in-rst stall ptr0", 32'(stall), 32'h2);
    check("in-rst rdata0", rdata[31:0], 32'h0);
    check("in-rst rdata1", rdata[63:32], 32'h0);
    // a store granted while in reset must be dropped
    drive(mk(2'b00, 2'b01, 2'b00, 2'b00, 12'h010, 12'h000, 32'h0BAD0BAD, 32'h0, 4'hF, 4'h0,
             2'b00, 2'b00, 32'h0, 32'h0));
    step();
    step();
    rst_n = 1'b1;
    drive(mk(2'b11, 2'b00, 2'b00, 2'b00, 12'h010, 12'h020, 32'h0, 32'h0, 4'h0, 4'h0,
             2'b00, 2'b00, 32'h0, 32'h0));
    #4;
    check("post-rst first grant", 32'(stall), 32'h2);
    step();
    #4;
    check("post-rst second grant", 32'(stall), 32'h1);
    check("post-rst rdata0", rdata[31:0], 32'hDEADBEEF);
    step();
    drive(mk(2'b00, 2'b01, 2'b00, 2'b01, 12'h040, 12'h000, 32'h77, 32'h0, 4'hF, 4'h0,
             2'b00, 2'b00, 32'h0, 32'h0));
    #4;
    check("post-rst sc stall", 32'(stall), 32'h0);
    check("post-rst rdata1", rdata[63:32], 32'h11BB33DD);
    step();
    drive(mk(2'b10, 2'b00, 2'b00, 2'b00, 12'h000, 12'h040, 32'h0, 32'h0, 4'h0, 4'h0,
             2'b00, 2'b00, 32'h0, 32'h0));
    #4;
    check("post-rst sc result", rdata[31:0], EXP_SC_RST);
    step();
    drive(idle);
    #4;
    check("post-rst mem 0x040", rdata[63:32], EXP_MEM_RST);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
